up_counter: RTL and testbench

- Parameterised, loadable, modulo up-counter with a programmable terminal value and a terminal-count flag.
- Used as the loop/index counter in the CNN layer datapath, e.g. for row, column and kernel indices.
- Counts from 0 (or a loaded value) up to cnt_upto, flags that value, and wraps to 0.

---
 rtl/up_counter_pkg.sv | 18 +
 rtl/up_counter.sv | 59 +++++
 tb/tb_up_counter.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/up_counter_pkg.sv
// Shared constants and the wrap/saturate mode type for up_counter.
// Build option UPCOUNTER_SAT_EN selects saturating mode instead of wrapping.
package up_counter_pkg;

  localparam int CNT_WIDTH_DEFAULT = 3;

  typedef enum logic {
    MODE_WRAP = 1'b0,
    MODE_SAT  = 1'b1
  } cnt_mode_e;

`ifdef UPCOUNTER_SAT_EN
  localparam cnt_mode_e CNT_MODE = MODE_SAT;
`else
  localparam cnt_mode_e CNT_MODE = MODE_WRAP;
`endif

endpackage

// File: rtl/up_counter.sv
// Loadable modulo up-counter with programmable terminal value and done flag.
// Define UPCOUNTER_SAT_EN to hold at cnt_upto instead of wrapping.
module up_counter
  import up_counter_pkg::*;
#(
  parameter int CNT_WIDTH = CNT_WIDTH_DEFAULT
) (
  input  logic                 cnt_clk,
  input  logic                 cnt_rst_b,
  input  logic                 cnt_en,
  input  logic                 cnt_ld_en,
  input  logic [CNT_WIDTH-1:0] cnt_ld_val,
  input  logic [CNT_WIDTH-1:0] cnt_upto,
  output logic [CNT_WIDTH-1:0] cnt_out,
  output logic                 cnt_done
);

  logic [CNT_WIDTH-1:0] cnt_reg;
  logic [CNT_WIDTH-1:0] cnt_next;
  logic                 at_upto;

  assign at_upto = (cnt_reg == cnt_upto);

  always_comb begin
    cnt_next = cnt_reg;
    if (cnt_ld_en) begin
      cnt_next = cnt_ld_val;
    end else if (cnt_en) begin
      if (at_upto) begin
`ifdef UPCOUNTER_SAT_EN
        cnt_next = cnt_reg;
`else
        cnt_next = '0;
`endif
      end else begin
        // Values above cnt_upto roll over through the natural modulo.
        cnt_next = cnt_reg + CNT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge cnt_clk or posedge cnt_rst_b) begin
    if (cnt_rst_b) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

  assign cnt_out = cnt_reg;

`ifdef UPCOUNTER_SAT_EN
  // Saturated state keeps the flag up even with enable low.
  assign cnt_done = at_upto & ~cnt_ld_en;
`else
  assign cnt_done = cnt_en & at_upto & ~cnt_ld_en;
`endif

endmodule

// File: tb/tb_up_counter.sv
// Randomised scoreboard bench for up_counter; the reference model follows
// the counting rules arithmetically and adapts to the UPCOUNTER_SAT_EN build.
module tb_up_counter;
  import up_counter_pkg::*;

  localparam int W = CNT_WIDTH_DEFAULT;
  localparam int MODV = 1 << W;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         en = 1'b0;
  logic         ld_en = 1'b0;
  logic [W-1:0] ld_val = '0;
  logic [W-1:0] upto = '0;
  logic [W-1:0] cnt_out;
  logic         cnt_done;

  typedef struct {
    int           idx;
    logic [W-1:0] out;
    logic         done;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   model = 0;
  int   txn = 0;
  bit   sat_mode;

  up_counter #(.CNT_WIDTH(W)) dut (
    .cnt_clk    (clk),
    .cnt_rst_b  (rst),
    .cnt_en     (en),
    .cnt_ld_en  (ld_en),
    .cnt_ld_val (ld_val),
    .cnt_upto   (upto),
    .cnt_out    (cnt_out),
    .cnt_done   (cnt_done)
  );

  always #5 clk = ~clk;

  // Drive one cycle at the falling edge, record what the DUT should show
  // during that cycle, then advance the model to the following rising edge.
  task automatic cycle(input bit r, input bit e, input bit l,
                       input int lv, input int u);
    exp_t x;
    @(negedge clk);
    rst = r; en = e; ld_en = l; ld_val = W'(lv); upto = W'(u);
    if (r) model = 0;
    x.idx  = txn;
    x.out  = W'(model);
    if (sat_mode) x.done = (model == u) && !l;
    else          x.done = e && (model == u) && !l;
    q.push_back(x);
    txn++;
    if (r)                  model = 0;
    else if (l)             model = lv;
    else if (e && model == u) model = sat_mode ? model : 0;
    else if (e)             model = (model + 1) % MODV;
  endtask

  // Continuous enable until the model reaches a target value (bounded).
  task automatic run_to(input int target, input int u);
    for (int i = 0; i < 2 * MODV && model != target; i++)
      cycle(0, 1, 0, 0, u);
  endtask

  // Monitor: one transaction per cycle, sampled 2 ns after the drive edge.
  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      #2;
      if (q.size() > 0) begin
        x = q.pop_front();
        checks += 2;
        $display("txn %0d: rst=%0b en=%0b ld=%0b ldv=%0d upto=%0d out=%0d done=%0b",
                 x.idx, rst, en, ld_en, ld_val, upto, cnt_out, cnt_done);
        if (cnt_out !== x.out) begin
          errors++;
          $display("FAIL cnt_out txn %0d: got %0d expected %0d", x.idx, cnt_out, x.out);
        end
        if (cnt_done !== x.done) begin
          errors++;
          $display("FAIL cnt_done txn %0d: got %0b expected %0b", x.idx, cnt_done, x.done);
        end
      end
    end
  end

  initial begin
    int wait_cycles;
    bit r, e, l;
    int lv, u;
    sat_mode = (CNT_MODE == MODE_SAT);

    // Reset for 10 ns, release, enable 10 ns later, count with upto=5.
    cycle(1, 0, 0, 0, 5);
    cycle(0, 0, 0, 0, 5);
    for (int i = 0; i < 14; i++) cycle(0, 1, 0, 0, 5);

    // Load has priority over counting.
    cycle(1, 0, 0, 0, 5);
    run_to(2, 5);
    cycle(0, 1, 1, 4, 5);
    for (int i = 0; i < 4; i++) cycle(0, 1, 0, 0, 5);

    // Load above the terminal value.
    cycle(0, 1, 1, 7, 5);
    for (int i = 0; i < 9; i++) cycle(0, 1, 0, 0, 5);

    // Enable gap at 3, then reset asserted between clock edges.
    cycle(1, 0, 0, 0, 5);
    run_to(3, 5);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 5);
    cycle(1, 1, 0, 0, 5);
    cycle(0, 1, 0, 0, 5);
    cycle(0, 1, 0, 0, 5);

    // upto = 0.
    cycle(1, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) cycle(0, 1, 0, 0, 0);

    // Run past the terminal value, then reload 1 and continue.
    cycle(1, 0, 0, 0, 5);
    for (int i = 0; i < 9; i++) cycle(0, 1, 0, 0, 5);
    cycle(0, 0, 0, 0, 5);
    cycle(0, 1, 1, 1, 5);
    for (int i = 0; i < 4; i++) cycle(0, 1, 0, 0, 5);

    // Full-range terminal value.
    cycle(1, 0, 0, 0, MODV - 1);
    for (int i = 0; i < 2 * MODV + 1; i++) cycle(0, 1, 0, 0, MODV - 1);

    // Randomised traffic; terminal value changes occasionally.
    u = 5;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 15) == 0) u = $urandom_range(0, MODV - 1);
      r  = ($urandom_range(0, 39) == 0);
      e  = ($urandom_range(0, 3) != 0);
      l  = !r && ($urandom_range(0, 9) == 0);
      lv = $urandom_range(0, MODV - 1);
      cycle(r, e, l, lv, u);
    end

    wait_cycles = 0;
    while (q.size() > 0 && wait_cycles < 20) begin
      @(negedge clk);
      wait_cycles++;
    end
    #5;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d transactions left, expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
